// File: rtl/jt12_eg_kon_seq.sv
// jt12_eg_kon_seq: key-on sequencer serialising per-operator key state onto the keyon_I slot stream
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   clk_en            slot advance enable
//   zero              marks the current slot as the last of the frame (qualified by clk_en)
//   kon_we, kon_din   key-on register write: [2:0] channel code, [7:4] S4,S3,S2,S1 key bits
//   csm_kon           CSM key-on request, sampled at the frame boundary
//   kon_busy          a captured write is waiting for the next frame boundary
//   kon_ovf           sticky: a write arrived while busy and was dropped
//   slot, keyon_I     slot index and its registered key state
module jt12_eg_kon_seq #(
    parameter int SLOTS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       zero,
    input  logic       kon_we,
    input  logic [7:0] kon_din,
    input  logic       csm_kon,
    output logic       kon_busy,
    output logic       kon_ovf,
    output logic [4:0] slot,
    output logic       keyon_I
);
    logic [SLOTS-1:0] kon_q, kon_d, eff;
    logic             csm_q, csm_d, busy_q, busy_d, ovf_q, ovf_d, key_q, key_d;
    logic [2:0]       pch_q, pch_d;
    logic [3:0]       pm_q, pm_d;
    logic [4:0]       slot_q, slot_d, nxt;
    logic             valid, cap, bnd, commit;
    logic [5:0]       ch_oh;
    logic             unused_bit;

    assign unused_bit = kon_din[3];
    assign valid      = kon_we & (kon_din[1:0] != 2'b11);
    assign cap        = valid & ~busy_q;

    always_comb begin
        nxt    = (zero || slot_q == 5'(SLOTS - 1)) ? 5'd0 : slot_q + 5'd1;
        bnd    = clk_en && nxt == 5'd0;
        commit = bnd && busy_q;
        ch_oh  = 6'b1 << pch_q;
        // pending mask is kept in array-group order: {S4, S2, S3, S1} for slot groups 18/12/6/0
        kon_d  = commit ? (kon_q & ~{4{ch_oh}}) |
                          ({{6{pm_q[3]}}, {6{pm_q[2]}}, {6{pm_q[1]}}, {6{pm_q[0]}}} & {4{ch_oh}})
                        : kon_q;
        csm_d  = bnd ? csm_kon : csm_q;
        // CSM forces the S3-of-channel-2... group slots 2, 8, 14, 20 on top of the array
        eff    = kon_d | (csm_d ? 24'h104104 : 24'h0);
        slot_d = clk_en ? nxt : slot_q;
        key_d  = clk_en ? eff[nxt] : key_q;
        busy_d = cap | (busy_q & ~commit);
        ovf_d  = ovf_q | (valid & busy_q);
        pch_d  = cap ? (kon_din[2] ? {1'b0, kon_din[1:0]} + 3'd3 : {1'b0, kon_din[1:0]}) : pch_q;
        pm_d   = cap ? {kon_din[7], kon_din[5], kon_din[6], kon_din[4]} : pm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kon_q  <= '0;
            csm_q  <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
            pch_q  <= '0;
            pm_q   <= '0;
            slot_q <= '0;
            key_q  <= 1'b0;
        end else begin
            kon_q  <= kon_d;
            csm_q  <= csm_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
            pch_q  <= pch_d;
            pm_q   <= pm_d;
            slot_q <= slot_d;
            key_q  <= key_d;
        end
    end

    assign kon_busy = busy_q;
    assign kon_ovf  = ovf_q;
    assign slot     = slot_q;
    assign keyon_I  = key_q;
endmodule

// File: tb/tb_jt12_eg_kon_seq.sv
// tb_jt12_eg_kon_seq: directed scoreboard bench for the key-on sequencer
module tb_jt12_eg_kon_seq;
    logic       clk = 1'b0, rst = 1'b1, clk_en = 1'b0, zero = 1'b0, kon_we = 1'b0, csm_kon = 1'b0;
    logic [7:0] kon_din = 8'h00;
    logic       kon_busy, kon_ovf, keyon_I;
    logic [4:0] slot;

    jt12_eg_kon_seq dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero), .kon_we(kon_we),
        .kon_din(kon_din), .csm_kon(csm_kon), .kon_busy(kon_busy), .kon_ovf(kon_ovf),
        .slot(slot), .keyon_I(keyon_I)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_err = 0;
    logic [5:0] sb[$];
    logic [23:0] m_arr = '0;
    logic       m_csm = 0, m_busy = 0, m_ovf = 0, m_key = 0;
    logic [4:0] m_slot = 0;
    int         m_c = 0;
    logic [7:0] m_din = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic z, input logic c);
        logic [4:0] ns;
        logic [5:0] e;
        clk_en = 1; zero = z; csm_kon = c;
        ns = (z || m_slot == 23) ? 5'd0 : m_slot + 5'd1;
        if (ns == 0) begin
            if (m_busy) begin
                m_arr[m_c]      = m_din[4];
                m_arr[6 + m_c]  = m_din[6];
                m_arr[12 + m_c] = m_din[5];
                m_arr[18 + m_c] = m_din[7];
                m_busy = 0;
            end
            m_csm = c;
        end
        m_slot = ns;
        m_key  = m_arr[ns] | (m_csm && (ns == 2 || ns == 8 || ns == 14 || ns == 20));
        sb.push_back({ns, m_key});
        @(posedge clk); #1;
        clk_en = 0; zero = 0; csm_kon = 0;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL scoreboard: observed empty expected entry");
        end else begin
            e = sb.pop_front();
            chk("slot", {3'b0, slot}, {3'b0, e[5:1]});
            chk("keyon", {7'b0, keyon_I}, {7'b0, e[0]});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d);
        logic v;
        v = d[1:0] != 2'b11;
        clk_en = 0; kon_we = 1; kon_din = d;
        if (v && !m_busy) begin
            m_busy = 1; m_din = d;
            m_c = d[2] ? 3 + int'(d[1:0]) : int'(d[1:0]);
        end else if (v) m_ovf = 1;
        @(posedge clk); #1;
        kon_we = 0;
        chk("busy_wr", {7'b0, kon_busy}, {7'b0, m_busy});
        chk("ovf_wr", {7'b0, kon_ovf}, {7'b0, m_ovf});
    endtask

    task automatic hold(input int n);
        clk_en = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("hold_slot", {3'b0, slot}, {3'b0, m_slot});
            chk("hold_keyon", {7'b0, keyon_I}, {7'b0, m_key});
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slot", {3'b0, slot}, 8'd0);
        chk("rst_keyon", {7'b0, keyon_I}, 8'd0);
        chk("rst_busy", {7'b0, kon_busy}, 8'd0);
        chk("rst_ovf", {7'b0, kon_ovf}, 8'd0);
        rst = 0;
        for (int i = 0; i < 48; i++) step(m_slot == 23, 1'b0);
        chk("idle_busy", {7'b0, kon_busy}, 8'd0);
        wr(8'hF0);
        run(24);
        chk("commit_busy", {7'b0, kon_busy}, 8'd0);
        run(24);
        wr(8'h00);
        run(48);
        wr(8'h16);
        run(48);
        wr(8'h83);
        chk("invalid_busy", {7'b0, kon_busy}, 8'd0);
        run(24);
        wr(8'h06);
        run(24);
        wr(8'h10);
        wr(8'h20);
        run(48);
        chk("ovf_sticky", {7'b0, kon_ovf}, 8'd1);
        wr(8'h00);
        run(24);
        run(23);
        step(1'b0, 1'b1);
        run(24);
        run(24);
        run(10);
        wr(8'h41);
        step(1'b1, 1'b0);
        chk("zero_busy", {7'b0, kon_busy}, 8'd0);
        run(8);
        hold(5);
        run(24);
        chk("ovf_before_rst", {7'b0, kon_ovf}, 8'd1);
        wr(8'hF1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst2_busy", {7'b0, kon_busy}, 8'd0);
        chk("rst2_ovf", {7'b0, kon_ovf}, 8'd0);
        chk("rst2_slot", {3'b0, slot}, 8'd0);
        m_arr = '0; m_csm = 0; m_busy = 0; m_ovf = 0; m_slot = 0; m_key = 0;
        run(48);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
